// File: rtl/scan_loader_if.sv
// Host/bank signal bundle for scan_loader: byte stream in/out, transfer control
// and the serial scan port towards the pattern-buffer bank.
interface scan_loader_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [2:0]        addr;
  logic              abort;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              ssel;
  logic [2:0]        saddr;
  logic              sin;
  logic              sout;

  modport master (
    output start, addr, abort, wr_data, wr_valid, sout,
    input  wr_ready, rd_data, rd_valid, busy, done, ssel, saddr, sin
  );

  modport slave (
    input  start, addr, abort, wr_data, wr_valid, sout,
    output wr_ready, rd_data, rd_valid, busy, done, ssel, saddr, sin
  );
endinterface

// File: rtl/scan_loader.sv
// scan_loader: shifts a valid/ready byte stream LSB-first into one addressed
// pattern buffer. Define SCAN_READBACK_EN to build the sout capture/readback path.
module scan_loader #(
  parameter int buffer_size  = 22,
  parameter int buffer_width = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  scan_loader_if.slave bus
);

  localparam int CNT_W = $clog2(buffer_size + 1);
  localparam int BIT_W = (buffer_width > 1) ? $clog2(buffer_width) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(buffer_size - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(buffer_width - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bcnt_q, bcnt_d;
  logic [buffer_width-1:0] sr_q, sr_d;
  logic [2:0]              saddr_q, saddr_d;
  logic                    sin_q, sin_d;
  logic                    ssel_q, ssel_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
`ifdef SCAN_READBACK_EN
  logic [buffer_width-1:0] cap_q, cap_d;
  logic [buffer_width-1:0] rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    saddr_d = saddr_q;
    sin_d   = 1'b0;
`ifdef SCAN_READBACK_EN
    cap_d      = cap_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          saddr_d = bus.addr;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.wr_valid && wr_ready_q) begin
          sr_d    = bus.wr_data;
          sin_d   = bus.wr_data[0];
          bcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Abort wins even over the final shift edge: no partial byte is reported.
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
`ifdef SCAN_READBACK_EN
          cap_d = buffer_width'({bus.sout, cap_q} >> 1);
`endif
          if (bcnt_q == LAST_BIT) begin
`ifdef SCAN_READBACK_EN
            rd_valid_d = 1'b1;
            rd_data_d  = buffer_width'({bus.sout, cap_q} >> 1);
`endif
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_q == LAST_BYTE) ? DONE : LOAD;
          end else begin
            bcnt_d = bcnt_q + BIT_W'(1);
            sr_d   = sr_q >> 1;
            sin_d  = sr_d[0];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs follow the next state, so they are valid for the whole cycle.
    ssel_d     = (state_d == SHIFT);
    wr_ready_d = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      saddr_q    <= '0;
      sin_q      <= 1'b0;
      ssel_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SCAN_READBACK_EN
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      saddr_q    <= saddr_d;
      sin_q      <= sin_d;
      ssel_q     <= ssel_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SCAN_READBACK_EN
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`endif
    end
  end

  // Pure datapath shift registers: their contents only matter once loaded.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
`ifdef SCAN_READBACK_EN
    cap_q <= cap_d;
`endif
  end

  assign bus.ssel     = ssel_q;
  assign bus.saddr    = saddr_q;
  assign bus.sin      = sin_q;
  assign bus.wr_ready = wr_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

`ifdef SCAN_READBACK_EN
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
`else
  logic unused_sout;
  assign unused_sout  = bus.sout;
  assign bus.rd_valid = 1'b0;
  assign bus.rd_data  = '0;
`endif

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader: bank chain model, transaction-level reference model
// with per-cycle compare, plus directed transfers with hand-computed literals.
module tb_scan_loader;
  localparam int BS = 22;
  localparam int BW = 8;
  localparam int CHAIN = BS * BW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scan_loader_if #(.DATA_W(BW)) bus ();

  scan_loader #(.buffer_size(BS), .buffer_width(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Bank: each buffer is one CHAIN-bit shift chain; first bit in is first bit out.
  // 0xA5 is bit-palindromic, so the preload reads back as 0xA5 in either order.
  logic [CHAIN-1:0] chain [8];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int a = 0; a < 8; a++) chain[a] <= {BS{8'hA5}};
    end else if (bus.ssel) begin
      chain[bus.saddr] <= {chain[bus.saddr][CHAIN-2:0], bus.sin};
    end
  end
  assign bus.sout = chain[bus.saddr][CHAIN-1];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: transfer-level view of which byte is in flight and what the
  // addressed buffer held before it.
  bit         m_active, m_loading, m_shifting, m_done, m_rdv, m_rdd_ok;
  int         m_k, m_bytes;
  logic [2:0] m_saddr;
  logic [7:0] m_byte, m_rdd;
  logic [7:0] content [8][BS];
  bit         cvalid [8];

  task automatic m_reset();
    m_active = 0; m_loading = 0; m_shifting = 0; m_done = 0; m_rdv = 0; m_rdd_ok = 0;
    m_k = 0; m_bytes = 0; m_saddr = 3'd0; m_byte = 8'h00; m_rdd = 8'h00;
    for (int a = 0; a < 8; a++) begin
      cvalid[a] = 1'b1;
      for (int j = 0; j < BS; j++) content[a][j] = 8'hA5;
    end
  endtask

  task automatic m_step();
    m_rdv = 0;
    if (m_done) begin
      m_done = 0;
      m_active = 0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active = 1; m_loading = 1; m_saddr = bus.addr; m_bytes = 0;
      end
    end else if (bus.abort) begin
      cvalid[m_saddr] = 1'b0;
      m_active = 0; m_loading = 0; m_shifting = 0;
    end else if (m_loading) begin
      if (bus.wr_valid) begin
        m_loading = 0; m_shifting = 1; m_k = 0; m_byte = bus.wr_data;
      end
    end else if (m_shifting) begin
      m_k++;
      if (m_k == BW) begin
        m_shifting = 0;
`ifdef SCAN_READBACK_EN
        m_rdv = 1;
`endif
        m_rdd = content[m_saddr][m_bytes];
        m_rdd_ok = cvalid[m_saddr];
        content[m_saddr][m_bytes] = m_byte;
        m_bytes++;
        if (m_bytes < BS) m_loading = 1;
        else m_done = 1;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("busy",     32'(bus.busy),     32'(m_active));
      chk("wr_ready", 32'(bus.wr_ready), 32'(m_loading));
      chk("ssel",     32'(bus.ssel),     32'(m_shifting));
      chk("sin",      32'(bus.sin),      32'((m_shifting && m_k < BW) ? m_byte[m_k] : 1'b0));
      chk("saddr",    32'(bus.saddr),    32'(m_saddr));
      chk("done",     32'(bus.done),     32'(m_done));
      chk("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
`ifdef SCAN_READBACK_EN
      if (m_rdv && m_rdd_ok) chk("rd_data", 32'(bus.rd_data), 32'(m_rdd));
`else
      chk("rd_data_tied", 32'(bus.rd_data), 32'h0);
`endif
    end
  end

  // Per-transfer observations
  int         t_cycles, t_ssel, t_bursts, t_rd;
  bit         t_done, t_aborted;
  logic [7:0] rdb  [BS];
  logic [7:0] sinb [BS];

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ssel"},     32'(bus.ssel),     32'h0);
    chk({tag, "_saddr"},    32'(bus.saddr),    32'h0);
    chk({tag, "_sin"},      32'(bus.sin),      32'h0);
    chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'h0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'h0);
    chk({tag, "_rd_data"},  32'(bus.rd_data),  32'h0);
    chk({tag, "_busy"},     32'(bus.busy),     32'h0);
    chk({tag, "_done"},     32'(bus.done),     32'h0);
  endtask

  task automatic do_transfer(input logic [2:0] a, input logic [7:0] xorv,
                             input int stall_byte, input int stall_len,
                             input int abort_byte, input int abort_k);
    int  bidx, cur, kpos, stall_left;
    bit  prev_ssel, aborting;
    t_cycles = 1; t_ssel = 0; t_bursts = 0; t_rd = 0; t_done = 0; t_aborted = 0;
    for (int j = 0; j < BS; j++) begin rdb[j] = 8'h00; sinb[j] = 8'h00; end
    bidx = 0; cur = -1; kpos = 0; stall_left = stall_len; prev_ssel = 0; aborting = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.addr = a; bus.abort = 1'b0; bus.wr_valid = 1'b0;
    for (int it = 0; it < 600; it++) begin
      @(negedge clk);
      bus.start = 1'b0;
      t_cycles++;
      if (aborting) begin
        chk("abort_ssel",     32'(bus.ssel),     32'h0);
        chk("abort_busy",     32'(bus.busy),     32'h0);
        chk("abort_rd_valid", 32'(bus.rd_valid), 32'h0);
        bus.abort = 1'b0;
        t_aborted = 1;
        break;
      end
      if (bus.ssel) begin
        if (!prev_ssel) t_bursts++;
        t_ssel++;
        if (cur >= 0 && cur < BS && kpos < BW) sinb[cur][kpos] = bus.sin;
        if (cur == abort_byte && kpos == abort_k) begin
          bus.abort = 1'b1;
          aborting = 1;
        end
        kpos++;
      end
      prev_ssel = bus.ssel;
      if (bus.rd_valid) begin
        if (t_rd < BS) rdb[t_rd] = bus.rd_data;
        t_rd++;
      end
      if (bus.done) begin
        t_done = 1;
        break;
      end
      if (bidx == stall_byte && stall_left > 0) begin
        bus.wr_valid = 1'b0;
        if (!bus.ssel && bus.busy) begin
          chk("stall_wr_ready", 32'(bus.wr_ready), 32'h1);
          stall_left--;
        end
      end else if (bidx < BS) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'(bidx) ^ xorv;
      end else begin
        bus.wr_valid = 1'b0;
      end
      if (bus.wr_valid && bus.wr_ready) begin
        cur = bidx;
        bidx++;
        kpos = 0;
      end
    end
    bus.wr_valid = 1'b0;
    if (!t_done && !t_aborted) chk("xfer_timeout", 32'h1, 32'h0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.addr = 3'd0; bus.abort = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;

    // Full transfer into buffer 5, data 0x00..0x15, valid held high
    do_transfer(3'd5, 8'h00, -1, 0, -1, -1);
    chk("t1_done",   32'(t_done),   32'h1);
    chk("t1_cycles", 32'(t_cycles), 32'd200);
    chk("t1_ssel",   32'(t_ssel),   32'd176);
    chk("t1_bursts", 32'(t_bursts), 32'd22);
    chk("t1_saddr",  32'(bus.saddr), 32'd5);
    chk("t1_sin_b1",  32'(sinb[1]),  32'h01);
    chk("t1_sin_b21", 32'(sinb[21]), 32'h15);
`ifdef SCAN_READBACK_EN
    chk("t1_rd_cnt", 32'(t_rd),     32'd22);
    chk("t1_rd0",    32'(rdb[0]),   32'hA5);
    chk("t1_rd21",   32'(rdb[21]),  32'hA5);
`else
    chk("t1_rd_cnt", 32'(t_rd),     32'd0);
`endif

    // Same buffer again with a 10-cycle stall before byte 3; reads back transfer 1
    do_transfer(3'd5, 8'h3C, 3, 10, -1, -1);
    chk("t2_done",   32'(t_done),   32'h1);
    chk("t2_cycles", 32'(t_cycles), 32'd210);
    chk("t2_ssel",   32'(t_ssel),   32'd176);
    chk("t2_sin_b3", 32'(sinb[3]),  32'h3F);
`ifdef SCAN_READBACK_EN
    chk("t2_rd_cnt", 32'(t_rd),     32'd22);
    chk("t2_rd0",    32'(rdb[0]),   32'h00);
    chk("t2_rd3",    32'(rdb[3]),   32'h03);
    chk("t2_rd21",   32'(rdb[21]),  32'h15);
`endif

    // Abort in shift cycle 4 of byte 7
    do_transfer(3'd3, 8'h00, -1, 0, 7, 4);
    chk("t3_aborted", 32'(t_aborted), 32'h1);
    chk("t3_done",    32'(t_done),    32'h0);
    chk("t3_ssel",    32'(t_ssel),    32'd61);
`ifdef SCAN_READBACK_EN
    chk("t3_rd_cnt",  32'(t_rd),      32'd7);
`else
    chk("t3_rd_cnt",  32'(t_rd),      32'd0);
`endif

    // New start after abort
    do_transfer(3'd2, 8'hC3, -1, 0, -1, -1);
    chk("t4_done",   32'(t_done),   32'h1);
    chk("t4_cycles", 32'(t_cycles), 32'd200);
    chk("t4_saddr",  32'(bus.saddr), 32'd2);
`ifdef SCAN_READBACK_EN
    chk("t4_rd5",    32'(rdb[5]),   32'hA5);
`endif

    // Asynchronous reset in the middle of a shift burst
    @(negedge clk);
    bus.start = 1'b1; bus.addr = 3'd6; bus.wr_valid = 1'b1; bus.wr_data = 8'h5A;
    n = 0;
    for (int i = 0; i < 100 && n < 12; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.ssel) n++;
    end
    chk("rst_pre_ssel", 32'(bus.ssel), 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ssel", 32'(bus.ssel), 32'h0);
    chk("rst_async_sin",  32'(bus.sin),  32'h0);
    chk("rst_async_busy", 32'(bus.busy), 32'h0);
    bus.wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_rel");

    // Transfer after reset: bank was re-preloaded
    do_transfer(3'd5, 8'h00, -1, 0, -1, -1);
    chk("t5_done",   32'(t_done),   32'h1);
    chk("t5_cycles", 32'(t_cycles), 32'd200);
`ifdef SCAN_READBACK_EN
    chk("t5_rd0",    32'(rdb[0]),   32'hA5);
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/scan_loader.md
# scan_loader

Serial scan-chain initiator for the pattern-buffer bank. It takes pattern bytes over a valid/ready byte stream and shifts them into one addressed pattern buffer by driving `ssel`, `saddr` and `sin`. At the same time it captures the buffer's previous contents from `sout` and returns them as bytes. It sits between the host/configuration logic and the `sin/sout/ssel/saddr` port of the buffer bank.

## Interface
Parameters:
- `buffer_size`, 22: bytes per pattern buffer; one transfer equals this many bytes.
- `buffer_width`, 8: bits per byte; also the shift cycles per byte.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a transfer. Sampled only in IDLE.
- `addr`  in  3: target buffer, 0..7. Sampled with `start`.
- `abort`  in  1: terminate the current transfer.
- `wr_data`  in  `buffer_width`: next pattern byte to shift in.
- `wr_valid`  in  1: `wr_data` is valid.
- `wr_ready`  out  1: loader will accept a byte this cycle.
- `rd_data`  out  `buffer_width`: byte captured from `sout`.
- `rd_valid`  out  1: one-cycle strobe for `rd_data`. There is no backpressure.
- `busy`  out  1: a transfer is in progress (any state except IDLE).
- `done`  out  1: one-cycle pulse when a transfer completes normally.
- `ssel`  out  1: scan enable to the bank. The addressed buffer shifts on every edge while high.
- `saddr`  out  3: buffer select to the bank.
- `sin`  out  1: serial data to the bank.
- `sout`  in  1: serial data from the bank.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- **IDLE**
  - `start`=1 latches `addr` into `saddr`, clears the byte counter and goes to LOAD.
  - `saddr` holds its value until the next accepted `start`.
- **LOAD**
  - `wr_ready`=1.
  - On `wr_valid`&&`wr_ready`, latch `wr_data` into the shift register and go to SHIFT.
  - `wr_valid` held low stalls indefinitely; `ssel` stays 0 while stalled.
- **SHIFT**
  - `ssel`=1 for exactly `buffer_width` consecutive cycles.
  - In shift cycle k (0-based), `sin` = byte bit k (LSB first).
  - `sout` is sampled on the rising edge that ends cycle k and stored as capture bit k.
- **After the last shift cycle**
  - `rd_valid` pulses for 1 cycle with the captured byte.
  - Byte counter increments.
  - If counter < `buffer_size`, go to LOAD; `wr_ready` may be high in the same cycle as `rd_valid`.
  - Otherwise go to DONE.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- Byte counter is `$clog2(buffer_size+1)` bits wide; the bit counter is `$clog2(buffer_width)` bits wide. Neither wraps within a transfer.
- **abort** (any non-IDLE state)
  - Next state is IDLE.
  - `ssel` goes 0 from the next cycle.
  - No `done`, and no `rd_valid` for a partial byte.
  - The target buffer is left partially shifted; that is the user's responsibility.
- `abort` has priority over a same-cycle `wr_valid` handshake, and over the final shift edge.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: `start` wins.
- `sin` = 0 whenever `ssel` = 0.

## Timing
- Reset values: `ssel`=0, `saddr`=0, `sin`=0, `wr_ready`=0, `rd_valid`=0, `rd_data`=0, `busy`=0, `done`=0.
- Reset is asynchronous. Asserting `rst_n` mid-transfer drops `ssel` immediately, with no clock edge required.
- All outputs are registered; no combinational path from any input to any output.
- `start` at edge N: `busy`=1 and `wr_ready`=1 from cycle N+1.
- Handshake at edge M: `ssel`=1 during cycles M+1 .. M+`buffer_width`. `rd_valid` is high in cycle M+`buffer_width`+1.
- Minimum per byte: 1 LOAD cycle + `buffer_width` SHIFT cycles, i.e. 9 with defaults.
- Minimum full transfer: `buffer_size`·(`buffer_width`+1) + 2 cycles = 200 with defaults.

## Configuration
- `SCAN_READBACK_EN`
  - Defined: capture path as described above.
  - Undefined: `sout` is ignored, no capture register is built, and `rd_valid` and `rd_data` are tied 0. Handshake and shift timing are unchanged.

## Test plan
- **Full transfer.** `addr`=5, 22 bytes 0x00..0x15 with `wr_valid` held high.
  - `saddr`=5 throughout.
  - 176 `ssel` cycles, in 22 bursts of 8.
  - `sin` LSB first.
  - `done` pulse at cycle 200.
- **Readback.** Bank model preloaded with 0xA5 at every position.
  - 22 `rd_valid` strobes, each `rd_data`=0xA5.
  - Second transfer returns the bytes written by the first.
- **Stall.** `wr_valid` low for 10 cycles before byte 3.
  - `ssel`=0 and `wr_ready`=1 for those cycles.
  - No extra shifts; total `ssel` count still 176.
- **Abort.** Assert `abort` in shift cycle 4 of byte 7.
  - `ssel`=0 next cycle.
  - No `rd_valid` for byte 7.
  - No `done`; `busy`=0.
  - New `start` accepted.
- **Reset.** `rst_n` low mid-SHIFT.
  - `ssel`, `sin`, `busy` go 0 asynchronously.
  - After release, all outputs are at reset values.
- **Macro off.** Build without `SCAN_READBACK_EN`.
  - `rd_valid` never 1.
  - Shift timing identical to the first scenario.
